// File: rtl/keypad_emulator_if.sv
// Command channel for keypad_emulator.
//   cmd_valid  : press command present (master -> slave)
//   cmd_ready  : emulator can accept a command (slave -> master)
//   cmd_key    : hex key to press, 0x0-0xF (master -> slave)
//   cmd_bounce : 1 = inject contact bounce at press and release (master -> slave)
interface keypad_emulator_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_key;
   logic       cmd_bounce;

   modport master (output cmd_valid, cmd_key, cmd_bounce, input cmd_ready);
   modport slave  (input cmd_valid, cmd_key, cmd_bounce, output cmd_ready);
endinterface

// File: rtl/keypad_emulator.sv
// Behavioural 4x4 keypad: accepts one key-press command at a time, closes the
// matching switch contact for a programmed time (optionally with bounce at
// press and release), and reflects column drive onto the row lines.
// Ports:
//   clk         : system clock
//   reset       : synchronous active-low reset
//   cmd         : command channel (slave side of keypad_emulator_if)
//   keypad_vert : column drive from scanner, active-high, may be multi-hot
//   keypad_hori : row sense to scanner, active-high (combinational)
//   busy        : press sequence in progress
//   done        : one-cycle pulse on sequence completion
//   key_count   : completed presses, wraps 255 -> 0
//
// state      | meaning
// -----------+----------------------------------------------------
// IDLE       | contact open, ready for a command
// BOUNCE_IN  | contact toggling every BOUNCE_PERIOD, starting closed
// HELD       | contact closed for PRESS_CYCLES
// BOUNCE_OUT | contact toggling every BOUNCE_PERIOD, starting open
// GAP        | contact open for RELEASE_CYCLES before next command
module keypad_emulator #(
   parameter int PRESS_CYCLES   = 200,
   parameter int RELEASE_CYCLES = 200,
   parameter int BOUNCE_CYCLES  = 16,
   parameter int BOUNCE_PERIOD  = 2
) (
   input  logic              clk,
   input  logic              reset,
   keypad_emulator_if.slave  cmd,
   input  logic [3:0]        keypad_vert,
   output logic [3:0]        keypad_hori,
   output logic              busy,
   output logic              done,
   output logic [7:0]        key_count
);

   // zero-valued parameters behave as 1
   localparam int P_EFF  = (PRESS_CYCLES   < 1) ? 1 : PRESS_CYCLES;
   localparam int R_EFF  = (RELEASE_CYCLES < 1) ? 1 : RELEASE_CYCLES;
   localparam int B_EFF  = (BOUNCE_CYCLES  < 1) ? 1 : BOUNCE_CYCLES;
   localparam int BP_EFF = (BOUNCE_PERIOD  < 1) ? 1 : BOUNCE_PERIOD;
   localparam int MAX_A  = (P_EFF > R_EFF)  ? P_EFF : R_EFF;
   localparam int MAX_B  = (B_EFF > BP_EFF) ? B_EFF : BP_EFF;
   localparam int MAX_P  = (MAX_A > MAX_B)  ? MAX_A : MAX_B;
   localparam int CW     = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] P_LOAD  = CW'(P_EFF - 1);
   localparam logic [CW-1:0] R_LOAD  = CW'(R_EFF - 1);
   localparam logic [CW-1:0] B_LOAD  = CW'(B_EFF - 1);
   localparam logic [CW-1:0] PH_LOAD = CW'(BP_EFF - 1);

   typedef enum logic [2:0] {IDLE, BOUNCE_IN, HELD, BOUNCE_OUT, GAP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_dec;
   logic [CW-1:0] ph, ph_nxt;
   logic          contact, contact_nxt;
   logic [1:0]    row, row_nxt;
   logic [1:0]    col, col_nxt;
   logic          bounce, bounce_nxt;
   logic          done_nxt;
   logic [7:0]    count_nxt;

   // {row, col} of each key in the matrix
   function automatic logic [3:0] key_pos(input logic [3:0] key);
      logic [3:0] pos;
      case (key)
         4'h1: pos = {2'd0, 2'd0};
         4'h2: pos = {2'd0, 2'd1};
         4'h3: pos = {2'd0, 2'd2};
         4'hA: pos = {2'd0, 2'd3};
         4'h4: pos = {2'd1, 2'd0};
         4'h5: pos = {2'd1, 2'd1};
         4'h6: pos = {2'd1, 2'd2};
         4'hB: pos = {2'd1, 2'd3};
         4'h7: pos = {2'd2, 2'd0};
         4'h8: pos = {2'd2, 2'd1};
         4'h9: pos = {2'd2, 2'd2};
         4'hC: pos = {2'd2, 2'd3};
         4'hE: pos = {2'd3, 2'd0};
         4'h0: pos = {2'd3, 2'd1};
         4'hF: pos = {2'd3, 2'd2};
         default: pos = {2'd3, 2'd3};  // 4'hD
      endcase
      return pos;
   endfunction

   assign cnt_dec       = cnt - CW'(1);
   assign busy          = (state != IDLE);
   assign cmd.cmd_ready = (state == IDLE);
   assign keypad_hori   = (contact && keypad_vert[col]) ? (4'b0001 << row) : 4'b0000;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         ph        <= '0;
         contact   <= 1'b0;
         row       <= 2'd0;
         col       <= 2'd0;
         bounce    <= 1'b0;
         done      <= 1'b0;
         key_count <= 8'd0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ph        <= ph_nxt;
         contact   <= contact_nxt;
         row       <= row_nxt;
         col       <= col_nxt;
         bounce    <= bounce_nxt;
         done      <= done_nxt;
         key_count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      ph_nxt      = ph;
      contact_nxt = contact;
      row_nxt     = row;
      col_nxt     = col;
      bounce_nxt  = bounce;
      done_nxt    = 1'b0;
      count_nxt   = key_count;
      case (state)
         IDLE: begin
            if (cmd.cmd_valid) begin
               {row_nxt, col_nxt} = key_pos(cmd.cmd_key);
               bounce_nxt  = cmd.cmd_bounce;
               contact_nxt = 1'b1;
               ph_nxt      = PH_LOAD;
               if (cmd.cmd_bounce) begin
                  state_nxt = BOUNCE_IN;
                  cnt_nxt   = B_LOAD;
               end else begin
                  state_nxt = HELD;
                  cnt_nxt   = P_LOAD;
               end
            end
         end
         BOUNCE_IN, BOUNCE_OUT: begin
            // phase counter expires every BOUNCE_PERIOD cycles and flips the contact
            if (ph == '0) begin
               contact_nxt = ~contact;
               ph_nxt      = PH_LOAD;
            end else begin
               ph_nxt = ph - CW'(1);
            end
            if (cnt == '0) begin
               if (state == BOUNCE_IN) begin
                  state_nxt   = HELD;
                  contact_nxt = 1'b1;
                  cnt_nxt     = P_LOAD;
               end else begin
                  state_nxt   = GAP;
                  contact_nxt = 1'b0;
                  cnt_nxt     = R_LOAD;
               end
            end else begin
               cnt_nxt = cnt_dec;
            end
         end
         HELD: begin
            if (cnt == '0) begin
               contact_nxt = 1'b0;
               if (bounce) begin
                  state_nxt = BOUNCE_OUT;
                  cnt_nxt   = B_LOAD;
                  ph_nxt    = PH_LOAD;
               end else begin
                  state_nxt = GAP;
                  cnt_nxt   = R_LOAD;
               end
            end else begin
               cnt_nxt = cnt_dec;
            end
         end
         GAP: begin
            if (cnt == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               count_nxt = key_count + 8'd1;
            end else begin
               cnt_nxt = cnt_dec;
            end
         end
         default: begin
            state_nxt   = IDLE;
            contact_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

   localparam int P  = 4;
   localparam int R  = 3;
   localparam int B  = 6;
   localparam int BP = 2;

   logic       clk;
   logic       reset;
   logic [3:0] keypad_vert;
   logic [3:0] keypad_hori;
   logic       busy;
   logic       done;
   logic [7:0] key_count;

   keypad_emulator_if cmd_if();

   keypad_emulator #(
      .PRESS_CYCLES(P), .RELEASE_CYCLES(R), .BOUNCE_CYCLES(B), .BOUNCE_PERIOD(BP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cmd(cmd_if),
      .keypad_vert(keypad_vert),
      .keypad_hori(keypad_hori),
      .busy(busy),
      .done(done),
      .key_count(key_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // key layout, index = row*4 + col
   logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                           4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC,
                           4'hE, 4'h0, 4'hF, 4'hD};

   // contact level k cycles after the accepting edge
   function automatic bit contact_at(input int k, input bit b);
      if (k < 1) return 1'b0;
      if (!b) return (k <= P);
      if (k <= B) return (((k - 1) / BP) % 2) == 0;
      if (k <= B + P) return 1'b1;
      if (k <= 2 * B + P) return (((k - B - P - 1) / BP) % 2) == 1;
      return 1'b0;
   endfunction

   function automatic int seq_len(input bit b);
      return b ? (2 * B + P + R) : (P + R);
   endfunction

   // reference model: mk = position within current sequence, 0 = idle
   int   mk = 0;
   int   m_row = 0;
   int   m_col = 0;
   bit   m_bounce = 1'b0;
   bit   m_done = 1'b0;
   int   m_count = 0;
   bit   chk_en = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         mk = 0; m_done = 1'b0; m_count = 0; chk_en = 1'b1;
      end else begin
         m_done = 1'b0;
         if (mk == 0) begin
            if (cmd_if.cmd_valid) begin
               mk = 1;
               m_bounce = cmd_if.cmd_bounce;
               for (int i = 0; i < 16; i++)
                  if (km[i] == cmd_if.cmd_key) begin m_row = i / 4; m_col = i % 4; end
            end
         end else if (mk == seq_len(m_bounce)) begin
            mk = 0; m_done = 1'b1; m_count = (m_count + 1) % 256;
         end else begin
            mk++;
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] exp_h;
      if (chk_en) begin
         exp_h = (contact_at(mk, m_bounce) && keypad_vert[m_col]) ? 4'(1 << m_row) : 4'b0000;
         check("cyc_hori", 32'(keypad_hori), 32'(exp_h));
         check("cyc_busy", 32'(busy), 32'(mk != 0));
         check("cyc_ready", 32'(cmd_if.cmd_ready), 32'(mk == 0));
         check("cyc_done", 32'(done), 32'(m_done));
         check("cyc_count", 32'(key_count), 32'(m_count));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      logic [31:0] hv, dv, pat;
      int ndone;
      reset = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_key = 4'h0;
      cmd_if.cmd_bounce = 1'b0;
      keypad_vert = 4'b0000;

      // model pins
      pat = '0;
      for (int k = 1; k <= 20; k++) pat[k] = contact_at(k, 1'b1);
      check("model_bounce_pattern", pat, 32'h67E6);
      pat = '0;
      for (int k = 1; k <= 8; k++) pat[k] = contact_at(k, 1'b0);
      check("model_plain_pattern", pat, 32'h1E);

      tick(3);
      check("rst_hori", 32'(keypad_hori), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ready", 32'(cmd_if.cmd_ready), 32'h1);
      check("rst_done", 32'(done), 32'h0);
      check("rst_count", 32'(key_count), 32'h0);
      reset = 1'b1;
      tick(1);

      // key 5, no bounce, column 1 driven
      keypad_vert = 4'b0010; cmd_if.cmd_key = 4'h5; cmd_if.cmd_valid = 1'b1;
      tick(1);
      cmd_if.cmd_valid = 1'b0;
      hv = '0; dv = '0;
      for (int j = 1; j <= 9; j++) begin
         if (j <= 8) hv[(j-1)*4 +: 4] = keypad_hori;
         dv[j] = done;
         tick(1);
      end
      check("k5_hori", hv, 32'h0000_2222);
      check("k5_done", dv, 32'h100);
      check("k5_count", 32'(key_count), 32'd1);

      // key D with a rotating column scan
      keypad_vert = 4'b0001; cmd_if.cmd_key = 4'hD; cmd_if.cmd_valid = 1'b1;
      tick(1);
      cmd_if.cmd_valid = 1'b0;
      hv = '0;
      for (int j = 1; j <= 8; j++) begin
         keypad_vert = 4'(1 << (j % 4));
         #1;
         hv[(j-1)*4 +: 4] = keypad_hori;
         tick(1);
      end
      tick(1);
      check("kD_scan_hori", hv, 32'h0000_0800);
      check("kD_count", 32'(key_count), 32'd2);

      // key 0 with bounce
      keypad_vert = 4'b0010; cmd_if.cmd_key = 4'h0; cmd_if.cmd_bounce = 1'b1; cmd_if.cmd_valid = 1'b1;
      tick(1);
      cmd_if.cmd_valid = 1'b0; cmd_if.cmd_bounce = 1'b0;
      hv = '0; dv = '0;
      for (int j = 1; j <= 21; j++) begin
         hv[j] = (keypad_hori == 4'b1000);
         dv[j] = done;
         tick(1);
      end
      check("k0_bounce_contact", hv, 32'h67E6);
      check("k0_bounce_done", dv, 32'h10_0000);
      check("k0_count", 32'(key_count), 32'd3);

      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      check("rst2_count", 32'(key_count), 32'd0);
      tick(1);

      // held cmd_valid: key 1 then A back to back; key change mid-sequence ignored
      keypad_vert = 4'b0001; cmd_if.cmd_key = 4'h1; cmd_if.cmd_valid = 1'b1;
      tick(1);
      cmd_if.cmd_key = 4'hA;
      hv = '0; dv = '0;
      for (int j = 1; j <= 16; j++) begin
         if (j == 9) begin cmd_if.cmd_valid = 1'b0; keypad_vert = 4'b1000; #1; end
         hv[j] = (keypad_hori == 4'b0001);
         dv[j] = done;
         tick(1);
      end
      check("b2b_hori", hv, 32'h1E1E);
      check("b2b_done", dv, 32'h1_0100);
      check("b2b_count", 32'(key_count), 32'd2);

      // reset during HELD of key 9
      keypad_vert = 4'b0100; cmd_if.cmd_key = 4'h9; cmd_if.cmd_valid = 1'b1;
      tick(1);
      cmd_if.cmd_valid = 1'b0;
      tick(1);
      check("k9_held_hori", 32'(keypad_hori), 32'h4);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      check("k9_rst_hori", 32'(keypad_hori), 32'h0);
      check("k9_rst_busy", 32'(busy), 32'h0);
      check("k9_rst_count", 32'(key_count), 32'h0);
      dv = '0;
      for (int j = 0; j < 10; j++) begin dv[0] = dv[0] | done; tick(1); end
      check("k9_no_done", dv, 32'h0);

      // 256 presses wrap key_count
      cmd_if.cmd_key = 4'h7; cmd_if.cmd_valid = 1'b1;
      ndone = 0;
      for (int c = 0; c < 3000 && ndone < 256; c++) begin
         tick(1);
         if (done) begin
            ndone++;
            if (ndone == 255) check("wrap_count_255", 32'(key_count), 32'd255);
         end
      end
      cmd_if.cmd_valid = 1'b0;
      check("wrap_done_pulses", 32'(ndone), 32'd256);
      check("wrap_count_0", 32'(key_count), 32'd0);
      tick(12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
